fetch_stage: RTL

Instruction-fetch stage. It owns the program counter and drives the address of the combinational instruction memory. It captures the returned word into an IF/ID pipeline register that the decode stage reads through a valid/ready handshake. It also handles stalls from decode, redirects from branch/jump resolution, and address-range and alignment faults.

---
 rtl/fetch_stage_if.sv | 41 ++++
 rtl/fetch_stage.sv | 74 +++++++
 2 files changed

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: the instruction-memory port plus the
// redirect inputs and the IF/ID valid/ready handshake towards decode.
// The master side is the fetch stage itself.
interface fetch_stage_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] instr_addr;
    logic [DATA_WIDTH-1:0] instr;
    logic                  redirect;
    logic [ADDR_WIDTH-1:0] redirect_target;
    logic                  id_ready;
    logic                  id_valid;
    logic [DATA_WIDTH-1:0] id_instr;
    logic [ADDR_WIDTH-1:0] id_pc;
    logic                  id_fault;

    modport master (
        output instr_addr,
        input  instr,
        input  redirect,
        input  redirect_target,
        input  id_ready,
        output id_valid,
        output id_instr,
        output id_pc,
        output id_fault
    );

    modport slave (
        input  instr_addr,
        output instr,
        output redirect,
        output redirect_target,
        output id_ready,
        input  id_valid,
        input  id_instr,
        input  id_pc,
        input  id_fault
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, reads a zero-latency instruction
// memory and presents the fetched word to decode through an IF/ID register
// with a valid/ready handshake. Redirects flush the register and reload
// the PC; fetches past the end of memory are marked faulty and turned
// into NOPs.
module fetch_stage #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    MEM_SIZE     = 512,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_stage_if.master bus,
    output logic          misalign_err,
    output logic [31:0]   fetch_count
);

    localparam logic [ADDR_WIDTH-3:0] MEM_WORDS = (ADDR_WIDTH-2)'(MEM_SIZE);
    localparam logic [DATA_WIDTH-1:0] NOP_INSTR = DATA_WIDTH'(32'h0000_0013);

    logic [ADDR_WIDTH-1:0] pc;
    logic                  id_valid_q;
    logic [DATA_WIDTH-1:0] id_instr_q;
    logic [ADDR_WIDTH-1:0] id_pc_q;
    logic                  id_fault_q;
    logic                  accept;
    logic                  load;
    logic                  out_of_range;

    // Handshake qualifiers and the range check on the current fetch address
    always_comb begin
        accept       = id_valid_q & bus.id_ready;
        load         = ~id_valid_q | bus.id_ready;
        out_of_range = (pc[ADDR_WIDTH-1:2] >= MEM_WORDS);
    end

    assign bus.instr_addr = pc;
    assign bus.id_valid   = id_valid_q;
    assign bus.id_instr   = id_instr_q;
    assign bus.id_pc      = id_pc_q;
    assign bus.id_fault   = id_fault_q;

    // PC / IF/ID register update: redirect beats a new load, otherwise hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc           <= RESET_VECTOR;
            id_valid_q   <= 1'b0;
            id_instr_q   <= '0;
            id_pc_q      <= '0;
            id_fault_q   <= 1'b0;
            misalign_err <= 1'b0;
            fetch_count  <= '0;
        end else begin
            if (accept) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (bus.redirect) begin
                pc         <= {bus.redirect_target[ADDR_WIDTH-1:2], 2'b00};
                id_valid_q <= 1'b0;
                if (bus.redirect_target[1:0] != 2'b00) begin
                    misalign_err <= 1'b1;
                end
            end else if (load) begin
                id_valid_q <= 1'b1;
                id_pc_q    <= pc;
                id_fault_q <= out_of_range;
                id_instr_q <= out_of_range ? NOP_INSTR : bus.instr;
                pc         <= pc + ADDR_WIDTH'(4);
            end
        end
    end

endmodule
